// File: rtl/edge_tx_if.sv
// edge_tx_if: frame request / serial output bundle of the marker transmitter.
//   start  - frame request, accepted when ready is high at a rising edge
//   din    - payload word, sampled only at the accept edge
//   ready  - high while idle (a frame can be accepted)
//   busy   - high while a frame is in progress (inverse of ready)
//   cout   - registered serial line
//   done   - one-cycle pulse marking frame completion
// Modports: master = frame source, slave = edge_tx.
interface edge_tx_if #(
  parameter int PAYLOAD_W = 8
);
  logic                 start;
  logic [PAYLOAD_W-1:0] din;
  logic                 ready;
  logic                 busy;
  logic                 cout;
  logic                 done;

  modport master (output start, output din, input ready, input busy, input cout, input done);
  modport slave  (input start, input din, output ready, output busy, output cout, output done);
endinterface

// File: rtl/edge_tx.sv
// edge_tx: transmit end of the serial marker protocol.
// Each accepted frame is sent on cout as the marker 1,0,1,1 (time order),
// then the payload MSB-first, then IDLE_GAP forced-low guard cycles, after
// which done pulses for one cycle and the block is ready again.
// Ports:
//   clk  - single clock, all state changes on its rising edge
//   rstn - asynchronous active-low reset
//   bus  - edge_tx_if slave modport (start/din in, ready/busy/cout/done out)
// Parameters:
//   PAYLOAD_W - payload bits per frame (1..16)
//   IDLE_GAP  - guard zeros after the payload (0..15)
module edge_tx #(
  parameter int PAYLOAD_W = 8,
  parameter int IDLE_GAP  = 2
) (
  input  logic     clk,
  input  logic     rstn,
  edge_tx_if.slave bus
);

  // Counter must cover the 4 marker cycles as well as payload and gap lengths.
  localparam int CNT_LEN  = (PAYLOAD_W > IDLE_GAP) ? PAYLOAD_W : IDLE_GAP;
  localparam int CNT_SPAN = (CNT_LEN > 4) ? CNT_LEN : 4;
  localparam int CNT_W    = $clog2(CNT_SPAN);

  localparam logic [CNT_W-1:0] LAST_MARK = CNT_W'(3);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = (IDLE_GAP > 0) ? CNT_W'(IDLE_GAP - 1) : '0;

  // Marker bits indexed by time slot: slot 0 is sent first.
  localparam logic [3:0] MARKER = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    DATA,
    GAP
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [PAYLOAD_W-1:0] shreg, shreg_d;
  logic                 cout_q, cout_d;
  logic                 done_q, done_d;
  logic [1:0]           mark_nxt;

  // In MARK, cnt is the slot currently on cout; the flop is loaded with the next one.
  assign mark_nxt = cnt[1:0] + 2'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      // NOTE: the payload register is cleared too so no stale frame data survives reset.
      shreg  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state  <= state_d;
      cnt    <= cnt_d;
      shreg  <= shreg_d;
      cout_q <= cout_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    cout_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = MARK;
          cnt_d   = '0;
          shreg_d = bus.din;
          cout_d  = MARKER[0];
        end
      end

      MARK: begin
        if (cnt == LAST_MARK) begin
          state_d = DATA;
          cnt_d   = '0;
          cout_d  = shreg[PAYLOAD_W-1];
          shreg_d = shreg << 1;
        end else begin
          cnt_d  = cnt + 1'b1;
          cout_d = MARKER[mark_nxt];
        end
      end

      DATA: begin
        if (cnt == LAST_DATA) begin
          cnt_d = '0;
          if (IDLE_GAP == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d   = cnt + 1'b1;
          cout_d  = shreg[PAYLOAD_W-1];
          shreg_d = shreg << 1;
        end
      end

      GAP: begin
        if (cnt == LAST_GAP) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.cout  = cout_q;
  assign bus.done  = done_q;

endmodule
